// File: rtl/pd_packet_serializer.sv
// pd_packet_serializer: snapshots PID, status and a payload vector on start,
// then streams a framed packet (header, status, payload MSW first, optional
// XOR checksum trailer) over a valid/ready word interface.
// Optional feature macro: PD_SER_CHECKSUM_EN adds the CSUM state and trailer.
module pd_packet_serializer #(
    parameter int unsigned WORD_W        = 16,
    parameter int unsigned PAYLOAD_WORDS = 18,
    parameter logic [7:0]  SYNC_BYTE     = 8'h54
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        pid,
    input  logic                              pid_en,
    input  logic                              status_flag,
    input  logic                              status_en,
    input  logic                              start,
    input  logic [PAYLOAD_WORDS*WORD_W-1:0]   payload,
    output logic [WORD_W-1:0]                 tx_data,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    output logic                              tx_last,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned CNT_W = $clog2(PAYLOAD_WORDS + 4);
    localparam int unsigned PAY_W = PAYLOAD_WORDS * WORD_W;
    localparam int unsigned SEL_W = $clog2(PAY_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_WORDS - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_STAT = 3'd2;
    localparam logic [2:0] ST_BODY = 3'd3;
`ifdef PD_SER_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd4;
`endif

    // Reject illegal parameterisations at elaboration
    generate
        if (WORD_W < 16) begin : g_bad_word_w
            $error("pd_packet_serializer: WORD_W must be >= 16");
        end
        if (PAYLOAD_WORDS < 1) begin : g_bad_payload_words
            $error("pd_packet_serializer: PAYLOAD_WORDS must be >= 1");
        end
    endgenerate

    logic [2:0]          r_state;
    logic [CNT_W-1:0]    r_idx;
    logic [7:0]          r_pid;
    logic                r_status;
    logic [7:0]          r_pid_snap;
    logic                r_status_snap;
    logic [PAY_W-1:0]    r_payload_snap;
    logic [WORD_W-1:0]   r_tx_data;
    logic                r_tx_valid;
    logic                r_tx_last;
    logic                r_busy;
    logic                r_done;
`ifdef PD_SER_CHECKSUM_EN
    logic [WORD_W-1:0]   r_csum;
    logic [WORD_W-1:0]   w_csum_nxt;
`endif

    logic [2:0]          w_state_nxt;
    logic [CNT_W-1:0]    w_idx_nxt;
    logic [WORD_W-1:0]   w_data_nxt;
    logic                w_valid_nxt;
    logic                w_last_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_snap_load;
    logic                w_xfer;
    logic [CNT_W-1:0]    w_idx_dec;
    logic [SEL_W-1:0]    w_dec_base;
    logic [WORD_W-1:0]   w_word_top;
    logic [WORD_W-1:0]   w_word_dec;

    assign w_xfer     = r_tx_valid && tx_ready;
    assign w_idx_dec  = r_idx - CNT_W'(1);
    assign w_dec_base = SEL_W'(w_idx_dec) * SEL_W'(WORD_W);
    assign w_word_top = r_payload_snap[PAY_W-1 -: WORD_W];
    assign w_word_dec = r_payload_snap[w_dec_base +: WORD_W];

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign tx_last  = r_tx_last;
    assign busy     = r_busy;
    assign done     = r_done;

    // PID and status holding registers, loadable at any time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pid    <= 8'h00;
            r_status <= 1'b0;
        end else begin
            if (pid_en) begin
                r_pid <= pid;
            end
            if (status_en) begin
                r_status <= status_flag;
            end
        end
    end

    // Frame shadow registers captured when a start is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pid_snap     <= 8'h00;
            r_status_snap  <= 1'b0;
            r_payload_snap <= '0;
        end else if (w_snap_load) begin
            r_pid_snap     <= r_pid;
            r_status_snap  <= r_status;
            r_payload_snap <= payload;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next registered outputs; everything holds unless a word transfers
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_tx_data;
        w_valid_nxt = r_tx_valid;
        w_last_nxt  = r_tx_last;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_snap_load = 1'b0;
`ifdef PD_SER_CHECKSUM_EN
        w_csum_nxt  = r_csum;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_HDR;
                    w_snap_load = 1'b1;
                    w_data_nxt  = WORD_W'({SYNC_BYTE, r_pid});
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
`ifdef PD_SER_CHECKSUM_EN
                    w_csum_nxt  = '0;
`endif
                end
            end
            ST_HDR: begin
                if (w_xfer) begin
                    w_state_nxt = ST_STAT;
                    w_data_nxt  = WORD_W'(r_status_snap);
`ifdef PD_SER_CHECKSUM_EN
                    w_csum_nxt  = r_csum ^ r_tx_data;
`endif
                end
            end
            ST_STAT: begin
                if (w_xfer) begin
                    w_state_nxt = ST_BODY;
                    w_idx_nxt   = LAST_IDX;
                    w_data_nxt  = w_word_top;
`ifdef PD_SER_CHECKSUM_EN
                    w_csum_nxt  = r_csum ^ r_tx_data;
                    w_last_nxt  = 1'b0;
`else
                    w_last_nxt  = (LAST_IDX == '0);
`endif
                end
            end
            ST_BODY: begin
                if (w_xfer) begin
                    if (r_idx == '0) begin
`ifdef PD_SER_CHECKSUM_EN
                        w_state_nxt = ST_CSUM;
                        w_data_nxt  = r_csum ^ r_tx_data;
                        w_csum_nxt  = r_csum ^ r_tx_data;
                        w_last_nxt  = 1'b1;
`else
                        w_state_nxt = ST_IDLE;
                        w_data_nxt  = '0;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
`endif
                    end else begin
                        w_idx_nxt   = w_idx_dec;
                        w_data_nxt  = w_word_dec;
`ifdef PD_SER_CHECKSUM_EN
                        w_csum_nxt  = r_csum ^ r_tx_data;
                        w_last_nxt  = 1'b0;
`else
                        w_last_nxt  = (w_idx_dec == '0);
`endif
                    end
                end
            end
`ifdef PD_SER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_xfer) begin
                    w_state_nxt = ST_IDLE;
                    w_data_nxt  = '0;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_data_nxt  = '0;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Registered outputs and word index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_idx      <= w_idx_nxt;
            r_tx_data  <= w_data_nxt;
            r_tx_valid <= w_valid_nxt;
            r_tx_last  <= w_last_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

`ifdef PD_SER_CHECKSUM_EN
    // Running XOR of every word sent so far in the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum <= '0;
        end else begin
            r_csum <= w_csum_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pd_packet_serializer.sv
// Testbench for pd_packet_serializer: directed frames with literal expectations
// plus a randomized phase checked every cycle against a queue-based frame model.
module tb_pd_packet_serializer;

    localparam int unsigned W     = 16;
    localparam int unsigned PW    = 18;
    localparam int unsigned PAY_W = PW * W;
`ifdef PD_SER_CHECKSUM_EN
    localparam int unsigned FRAME_WORDS = PW + 3;
`else
    localparam int unsigned FRAME_WORDS = PW + 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       pid;
    logic             pid_en;
    logic             status_flag;
    logic             status_en;
    logic             start;
    logic [PAY_W-1:0] payload;
    logic [W-1:0]     tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_last;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit           started = 1'b0;
    bit           m_active = 1'b0;
    bit           m_done = 1'b0;
    logic [7:0]   m_pid = 8'h00;
    logic         m_stat = 1'b0;
    logic [W-1:0] m_q[$];
    logic [W-1:0] rx[$];

    pd_packet_serializer #(
        .WORD_W        (W),
        .PAYLOAD_WORDS (PW),
        .SYNC_BYTE     (8'h54)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pid         (pid),
        .pid_en      (pid_en),
        .status_flag (status_flag),
        .status_en   (status_en),
        .start       (start),
        .payload     (payload),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_last     (tx_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Whole expected frame as a word list built from the snapshot values
    function automatic void build_frame();
        logic [W-1:0] x;
        m_q.delete();
        m_q.push_back({8'h54, m_pid});
        m_q.push_back(W'(m_stat));
        for (int k = PW - 1; k >= 0; k--) begin
            m_q.push_back(W'(payload >> (k * W)));
        end
`ifdef PD_SER_CHECKSUM_EN
        x = '0;
        foreach (m_q[j]) x = x ^ m_q[j];
        m_q.push_back(x);
`endif
        m_active = 1'b1;
    endfunction

    // Model update and transfer capture on each rising edge
    always @(posedge clk) begin
        started = 1'b1;
        if (!rst && tx_valid && tx_ready) rx.push_back(tx_data);
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_q.delete();
            m_pid    = 8'h00;
            m_stat   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                if (tx_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end else if (start) begin
                build_frame();
            end
            if (pid_en) m_pid = pid;
            if (status_en) m_stat = status_flag;
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (started) begin
            if (m_active) begin
                chk("tx_valid", 32'(tx_valid), 32'd1);
                chk("tx_data", 32'(tx_data), 32'(m_q[0]));
                chk("tx_last", 32'(tx_last), 32'(m_q.size() == 1));
                chk("busy", 32'(busy), 32'd1);
                chk("done", 32'(done), 32'd0);
            end else begin
                chk("tx_valid_idle", 32'(tx_valid), 32'd0);
                chk("tx_data_idle", 32'(tx_data), 32'd0);
                chk("tx_last_idle", 32'(tx_last), 32'd0);
                chk("busy_idle", 32'(busy), 32'd0);
                chk("done_idle", 32'(done), 32'(m_done));
            end
        end
    end

    task automatic wait_done(inout int cyc);
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run_frame(output int cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        wait_done(cyc);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b1; pid = 8'h00; pid_en = 1'b0;
        status_flag = 1'b0; status_en = 1'b0; tx_ready = 1'b1; payload = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(tx_valid), 32'd0);
        rst = 1'b0; start = 1'b0;

        // Basic frame
        pid = 8'h3C; pid_en = 1'b1; status_flag = 1'b1; status_en = 1'b1;
        for (int k = 0; k < PW; k++) payload[k*W +: W] = W'(16'h0100 + k);
        @(negedge clk);
        pid_en = 1'b0; status_en = 1'b0;
        rx.delete();
        run_frame(cyc);
        chk("basic_cycles", 32'(cyc), 32'(FRAME_WORDS + 1));
        chk("basic_count", 32'(rx.size()), 32'(FRAME_WORDS));
        chk("basic_hdr", 32'(rx[0]), 32'h543C);
        chk("basic_stat", 32'(rx[1]), 32'h0001);
        chk("basic_first_pay", 32'(rx[2]), 32'h0111);
        chk("basic_last_pay", 32'(rx[PW+1]), 32'h0100);
`ifdef PD_SER_CHECKSUM_EN
        chk("basic_csum", 32'(rx[PW+2]), 32'h543C);
`endif

        // Back-pressure on the status word
        rx.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        @(negedge clk);
        cyc++;
        chk("bp_status", 32'(tx_data), 32'h0001);
        tx_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cyc++;
            chk("bp_hold_data", 32'(tx_data), 32'h0001);
            chk("bp_hold_valid", 32'(tx_valid), 32'd1);
        end
        tx_ready = 1'b1;
        wait_done(cyc);
        chk("bp_cycles", 32'(cyc), 32'(FRAME_WORDS + 4));
        chk("bp_count", 32'(rx.size()), 32'(FRAME_WORDS));
        chk("bp_pay", 32'(rx[2]), 32'h0111);

        // PID reload and extra start mid-frame
        rx.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        repeat (4) begin @(negedge clk); cyc++; end
        pid = 8'h77; pid_en = 1'b1; start = 1'b1;
        @(negedge clk);
        cyc++;
        pid_en = 1'b0; start = 1'b0;
        wait_done(cyc);
        chk("reload_hdr_kept", 32'(rx[0]), 32'h543C);
        chk("reload_cycles", 32'(cyc), 32'(FRAME_WORDS + 1));
        rx.delete();
        run_frame(cyc);
        chk("reload_next_hdr", 32'(rx[0]), 32'h5477);

        // Reset during payload word 5
        rx.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        while (cyc < int'(PW) - 3) begin @(negedge clk); cyc++; end
        chk("rst_word5", 32'(tx_data), 32'h0105);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", 32'(done), 32'd0);
        end
        rx.delete();
        run_frame(cyc);
        chk("rst_fresh_hdr", 32'(rx[0]), 32'h5400);
        chk("rst_fresh_stat", 32'(rx[1]), 32'h0000);

        // Randomized traffic checked by the per-cycle model comparison
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < PW; k++) payload[k*W +: W] = W'($urandom);
            pid         = 8'($urandom);
            pid_en      = ($urandom_range(0, 7) == 0);
            status_flag = 1'($urandom);
            status_en   = ($urandom_range(0, 7) == 0);
            tx_ready    = ($urandom_range(0, 3) != 0);
            start       = ($urandom_range(0, 5) == 0);
            rst         = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0; pid_en = 1'b0; status_en = 1'b0; tx_ready = 1'b1;
        cyc = 0;
        while (busy && cyc < 100) begin @(negedge clk); cyc++; end
        chk("drain_idle", 32'(busy), 32'd0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
